l1_meta_arbiter: RTL and testbench
==================================

# l1_meta_arbiter

Arbiter and sequencer in front of the L1 data-cache tag/metadata array (64 sets × 8 ways, 2-bit coherence state + 21-bit tag per way). It shares the array's single read port among several lookup requesters with round-robin arbitration. It shares the single write port among writers with fixed priority, and throttles write bursts so reads are not starved. It also registers the requester ID of each accepted read and returns the response one cycle later with a per-way tag-match vector.

## Interface
Parameters:
- NUM_READERS, 3, number of read/lookup requesters (indexed 0..NUM_READERS-1)
- NUM_WRITERS, 2, number of write requesters; writer 0 has highest priority
- WAYS, 8, associativity; matches the metadata array
- IDX_W, 6, set-index width
- TAG_W, 21, tag width
- WRITE_BURST_MAX, 4, maximum consecutive write cycles while a read is pending

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rd_valid  in  NUM_READERS  per-requester read request
- rd_ready  out  NUM_READERS  per-requester grant; a read is accepted when rd_valid[i] & rd_ready[i]
- rd_idx  in  NUM_READERS*IDX_W  set index, requester i at slice i
- rd_tag  in  NUM_READERS*TAG_W  lookup tag for compare
- wr_valid  in  NUM_WRITERS  write request
- wr_ready  out  NUM_WRITERS  write grant
- wr_idx / wr_way_en / wr_coh / wr_tag  in  NUM_WRITERS×(IDX_W / WAYS / 2 / TAG_W)  write payload per writer
- meta_read_valid / meta_read_idx  out  1 / IDX_W  to array read port
- meta_read_ready  in  1  array read ready; low during array init and during any array write
- meta_write_valid / meta_write_idx / meta_write_way_en / meta_write_coh / meta_write_tag  out  1 / IDX_W / WAYS / 2 / TAG_W  to array write port
- meta_write_ready  in  1  array write ready; low during array init
- meta_resp_coh / meta_resp_tag  in  WAYS*2 / WAYS*TAG_W  array read data; way w at slice w, valid one cycle after read fire
- resp_valid  out  1  lookup result valid
- resp_id  out  NUM_READERS  one-hot requester of this result
- resp_hit_way  out  WAYS  way w set iff tag[w]==stored tag and coh[w]!=0
- resp_hit  out  1  |resp_hit_way
- resp_hit_coh  out  2  coh of lowest-index hitting way; 0 on miss

## Operation
- Write arbitration: lowest-index valid writer wins. meta_write_valid = any wr_valid & !throttle. wr_ready[i] = grant[i] & meta_write_ready & !throttle. The winner's payload is driven muxed to the meta_write_* outputs.
- Read arbitration: round-robin. The grant goes to the first valid requester strictly after rr_ptr, wrapping around. rd_ready[i] = grant[i] & meta_read_ready. rr_ptr updates to the winner only on a read fire. On reset, rr_ptr = NUM_READERS-1, so requester 0 wins first.
- The array blocks reads during writes. Reads are presented regardless, and fire only when meta_read_ready is high.
- Throttle: burst_cnt (clog2(WRITE_BURST_MAX+1) bits) increments on each write fire while any rd_valid is high. It clears on any cycle without a write fire or with no rd_valid. When burst_cnt == WRITE_BURST_MAX, throttle is asserted for exactly one cycle; burst_cnt clears in that cycle.
- Response: on read fire, the winner's one-hot and tag are registered into rsp_id / rsp_tag, and rsp_v is set. Next cycle, resp_valid = rsp_v. The compare is combinational against meta_resp_*.
- Array init: with meta_*_ready low, all rd_ready/wr_ready are 0 and no state changes occur except burst_cnt clearing.

## Timing
- Reset values: rd_ready=0, wr_ready=0 (also gated by the array's readies), resp_valid=0, resp_id=0, resp_hit_way=0, resp_hit=0, resp_hit_coh=0, burst_cnt=0, rr_ptr=NUM_READERS-1.
- Grant latency is 0 cycles: ready is combinational from valid and the array's readies. Read-to-response latency is exactly 1 cycle, with one response per accepted read and in order.
- Requester rules: a requester must hold valid and payload stable until it fires. Readies may depend on valid.
- Simultaneous read and write: the write fires and the array drops meta_read_ready, so the read waits. After WRITE_BURST_MAX back-to-back writes with a read pending, the next cycle has no write and the read fires.
- Reset asserted mid-operation: any pending response is dropped (resp_valid=0 next cycle).

## Test plan
- Reset, array init of 64 cycles with readies low, then reader 0 reads idx 5 → rd_ready[0]=1 only after meta_read_ready rises. Next cycle: resp_valid=1, resp_id=3'b001.
- Readers 0, 1 and 2 all valid continuously → grant order 0,1,2,0,1,2. rr_ptr holds while meta_read_ready=0.
- Writers 0 and 1 both valid → writer 0 fires first and wr_ready[1]=0 that cycle. Then writer 1 fires.
- Writer 0 valid for 10 cycles with reader 1 valid → writes fire in cycles 0–3, no write in cycle 4 (reader 1 fires), and writes resume in cycle 5.
- Write idx 9 way_en 8'h04 with tag 0x1ABCD and coh 2, then read idx 9 with tag 0x1ABCD → resp_hit_way=8'h04, resp_hit=1, resp_hit_coh=2. Read with tag 0x1ABCE → resp_hit=0, resp_hit_coh=0.
- Read fires, reset asserted the same cycle → resp_valid=0 the next cycle and rr_ptr returns to NUM_READERS-1.

Source files
------------

// File: rtl/l1_meta_arbiter.sv
// l1_meta_arbiter
// Arbiter and sequencer in front of the L1 data-cache tag/metadata array.
// The array's single read port is shared by NUM_READERS lookup requesters
// using round-robin arbitration. The single write port is shared by
// NUM_WRITERS writers using fixed priority, where writer 0 wins. Write bursts
// are throttled so that a waiting read is not starved. Each accepted read
// returns one cycle later with a per-way tag-match vector.
//
// Ports
//   clock, reset         clock; synchronous active-high reset
//   rd_valid/rd_ready    per-reader handshake; rd_idx/rd_tag packed per reader
//   wr_valid/wr_ready    per-writer handshake; wr_idx/wr_way_en/wr_coh/wr_tag
//                        packed per writer
//   meta_read_*          array read port (valid/idx out, ready in)
//   meta_write_*         array write port (valid/payload out, ready in)
//   meta_resp_coh/tag    array read data, one cycle after a read fires
//   resp_*               lookup result: requester one-hot, hit vector,
//                        hit flag, coherence state of the lowest hitting way
module l1_meta_arbiter #(
  parameter int NUM_READERS     = 3,
  parameter int NUM_WRITERS     = 2,
  parameter int WAYS            = 8,
  parameter int IDX_W           = 6,
  parameter int TAG_W           = 21,
  parameter int WRITE_BURST_MAX = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_READERS-1:0]       rd_valid,
  output logic [NUM_READERS-1:0]       rd_ready,
  input  logic [NUM_READERS*IDX_W-1:0] rd_idx,
  input  logic [NUM_READERS*TAG_W-1:0] rd_tag,
  input  logic [NUM_WRITERS-1:0]       wr_valid,
  output logic [NUM_WRITERS-1:0]       wr_ready,
  input  logic [NUM_WRITERS*IDX_W-1:0] wr_idx,
  input  logic [NUM_WRITERS*WAYS-1:0]  wr_way_en,
  input  logic [NUM_WRITERS*2-1:0]     wr_coh,
  input  logic [NUM_WRITERS*TAG_W-1:0] wr_tag,
  output logic                         meta_read_valid,
  output logic [IDX_W-1:0]             meta_read_idx,
  input  logic                         meta_read_ready,
  output logic                         meta_write_valid,
  output logic [IDX_W-1:0]             meta_write_idx,
  output logic [WAYS-1:0]              meta_write_way_en,
  output logic [1:0]                   meta_write_coh,
  output logic [TAG_W-1:0]             meta_write_tag,
  input  logic                         meta_write_ready,
  input  logic [WAYS*2-1:0]            meta_resp_coh,
  input  logic [WAYS*TAG_W-1:0]        meta_resp_tag,
  output logic                         resp_valid,
  output logic [NUM_READERS-1:0]       resp_id,
  output logic [WAYS-1:0]              resp_hit_way,
  output logic                         resp_hit,
  output logic [1:0]                   resp_hit_coh
);

  localparam int PTR_W  = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
  localparam int WPTR_W = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;
  localparam int CNT_W  = $clog2(WRITE_BURST_MAX + 1);

  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       rd_win;
  logic [NUM_READERS-1:0] rd_grant;
  logic                   read_fire;

  logic [WPTR_W-1:0]      wr_win;
  logic [NUM_WRITERS-1:0] wr_grant;
  logic                   write_fire;
  logic                   throttle;
  logic [CNT_W-1:0]       burst_cnt;

  logic                   rsp_v;
  logic [NUM_READERS-1:0] rsp_id;
  logic [TAG_W-1:0]       rsp_tag;

  // The round-robin search starts one past the last winner and wraps around.
  // As a result, the requester that was just served has the lowest priority.
  always_comb begin
    int   cand;
    logic found;
    cand     = 0;
    found    = 1'b0;
    rd_grant = '0;
    rd_win   = rr_ptr;
    for (int k = 1; k <= NUM_READERS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_READERS) cand = cand - NUM_READERS;
      if (!found && rd_valid[cand]) begin
        found          = 1'b1;
        rd_grant[cand] = 1'b1;
        rd_win         = PTR_W'(cand);
      end
    end
  end

  assign rd_ready        = rd_grant & {NUM_READERS{meta_read_ready}};
  assign meta_read_valid = |rd_valid;
  assign meta_read_idx   = rd_idx[int'(rd_win)*IDX_W +: IDX_W];
  assign read_fire       = meta_read_valid & meta_read_ready;

  // Fixed priority: the writer with the lowest index wins.
  always_comb begin
    logic found;
    found    = 1'b0;
    wr_grant = '0;
    wr_win   = '0;
    for (int w = 0; w < NUM_WRITERS; w++) begin
      if (!found && wr_valid[w]) begin
        found       = 1'b1;
        wr_grant[w] = 1'b1;
        wr_win      = WPTR_W'(w);
      end
    end
  end

  // When throttle is asserted, the write port is idle for one cycle. The
  // array then raises meta_read_ready, and the waiting read can get through.
  assign throttle          = (burst_cnt == CNT_W'(WRITE_BURST_MAX));
  assign meta_write_valid  = (|wr_valid) & ~throttle;
  assign wr_ready          = wr_grant & {NUM_WRITERS{meta_write_ready & ~throttle}};
  assign write_fire        = meta_write_valid & meta_write_ready;
  assign meta_write_idx    = wr_idx[int'(wr_win)*IDX_W +: IDX_W];
  assign meta_write_way_en = wr_way_en[int'(wr_win)*WAYS +: WAYS];
  assign meta_write_coh    = wr_coh[int'(wr_win)*2 +: 2];
  assign meta_write_tag    = wr_tag[int'(wr_win)*TAG_W +: TAG_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= PTR_W'(NUM_READERS - 1);
      burst_cnt <= '0;
      rsp_v     <= 1'b0;
      rsp_id    <= '0;
      rsp_tag   <= '0;
    end else begin
      if (read_fire) begin
        rr_ptr  <= rd_win;
        rsp_id  <= rd_grant;
        rsp_tag <= rd_tag[int'(rd_win)*TAG_W +: TAG_W];
      end
      rsp_v <= read_fire;
      // Count only the writes that fire while a read is waiting. The
      // throttle cycle clears the count because no write fires in it.
      if (!throttle && write_fire && (|rd_valid))
        burst_cnt <= burst_cnt + CNT_W'(1);
      else
        burst_cnt <= '0;
    end
  end

  // Tag compare against the array data that returns in the response cycle.
  // A way with coherence state 0 is invalid and never counts as a hit.
  always_comb begin
    resp_hit_way = '0;
    resp_hit_coh = 2'd0;
    for (int w = 0; w < WAYS; w++)
      resp_hit_way[w] = rsp_v && (meta_resp_tag[w*TAG_W +: TAG_W] == rsp_tag) &&
                        (meta_resp_coh[w*2 +: 2] != 2'd0);
    for (int w = WAYS - 1; w >= 0; w--)
      if (resp_hit_way[w]) resp_hit_coh = meta_resp_coh[w*2 +: 2];
  end

  assign resp_valid = rsp_v;
  assign resp_id    = rsp_v ? rsp_id : '0;
  assign resp_hit   = |resp_hit_way;

endmodule

// File: tb/tb_l1_meta_arbiter.sv
// Testbench for l1_meta_arbiter: a behavioural metadata array drives the
// array handshakes. Expected lookup results are queued when reads are issued
// and a negedge monitor compares them against the DUT responses.
module tb_l1_meta_arbiter;

  localparam int NR    = 3;
  localparam int NW    = 2;
  localparam int WAYS  = 8;
  localparam int IDX_W = 6;
  localparam int TAG_W = 21;
  localparam int WBM   = 4;

  logic                  clock;
  logic                  reset;
  logic [NR-1:0]         rd_valid;
  logic [NR-1:0]         rd_ready;
  logic [NR*IDX_W-1:0]   rd_idx;
  logic [NR*TAG_W-1:0]   rd_tag;
  logic [NW-1:0]         wr_valid;
  logic [NW-1:0]         wr_ready;
  logic [NW*IDX_W-1:0]   wr_idx;
  logic [NW*WAYS-1:0]    wr_way_en;
  logic [NW*2-1:0]       wr_coh;
  logic [NW*TAG_W-1:0]   wr_tag;
  logic                  meta_read_valid;
  logic [IDX_W-1:0]      meta_read_idx;
  logic                  meta_read_ready;
  logic                  meta_write_valid;
  logic [IDX_W-1:0]      meta_write_idx;
  logic [WAYS-1:0]       meta_write_way_en;
  logic [1:0]            meta_write_coh;
  logic [TAG_W-1:0]      meta_write_tag;
  logic                  meta_write_ready;
  logic [WAYS*2-1:0]     meta_resp_coh;
  logic [WAYS*TAG_W-1:0] meta_resp_tag;
  logic                  resp_valid;
  logic [NR-1:0]         resp_id;
  logic [WAYS-1:0]       resp_hit_way;
  logic                  resp_hit;
  logic [1:0]            resp_hit_coh;

  logic array_up;
  logic array_block;

  typedef struct packed {
    logic [NR-1:0]   id;
    logic [WAYS-1:0] way;
    logic            hit;
    logic [1:0]      coh;
  } resp_t;

  resp_t exp_q[$];
  int    checks_total  = 0;
  int    checks_passed = 0;

  logic [1:0]       mem_coh [64][WAYS];
  logic [TAG_W-1:0] mem_tag [64][WAYS];

  l1_meta_arbiter #(
    .NUM_READERS(NR), .NUM_WRITERS(NW), .WAYS(WAYS),
    .IDX_W(IDX_W), .TAG_W(TAG_W), .WRITE_BURST_MAX(WBM)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx), .rd_tag(rd_tag),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_way_en(wr_way_en), .wr_coh(wr_coh), .wr_tag(wr_tag),
    .meta_read_valid(meta_read_valid), .meta_read_idx(meta_read_idx),
    .meta_read_ready(meta_read_ready),
    .meta_write_valid(meta_write_valid), .meta_write_idx(meta_write_idx),
    .meta_write_way_en(meta_write_way_en), .meta_write_coh(meta_write_coh),
    .meta_write_tag(meta_write_tag), .meta_write_ready(meta_write_ready),
    .meta_resp_coh(meta_resp_coh), .meta_resp_tag(meta_resp_tag),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_hit_way(resp_hit_way),
    .resp_hit(resp_hit), .resp_hit_coh(resp_hit_coh)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The array is not ready during init. While a write is in flight it
  // blocks reads.
  assign meta_write_ready = array_up & ~array_block;
  assign meta_read_ready  = array_up & ~array_block & ~(meta_write_valid & meta_write_ready);

  // Behavioural metadata array. Read data is registered, so it is valid one
  // cycle after the read fires.
  always @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < 64; s++)
        for (int w = 0; w < WAYS; w++) begin
          mem_coh[s][w] <= 2'd0;
          mem_tag[s][w] <= '0;
        end
      meta_resp_coh <= '0;
      meta_resp_tag <= '0;
    end else begin
      if (meta_write_valid && meta_write_ready)
        for (int w = 0; w < WAYS; w++)
          if (meta_write_way_en[w]) begin
            mem_coh[meta_write_idx][w] <= meta_write_coh;
            mem_tag[meta_write_idx][w] <= meta_write_tag;
          end
      if (meta_read_valid && meta_read_ready)
        for (int w = 0; w < WAYS; w++) begin
          meta_resp_coh[w*2 +: 2]         <= mem_coh[meta_read_idx][w];
          meta_resp_tag[w*TAG_W +: TAG_W] <= mem_tag[meta_read_idx][w];
        end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Loads one writer's payload slot.
  task automatic applyStimulus(input int w, input logic [IDX_W-1:0] idx,
                               input logic [WAYS-1:0] way_en, input logic [1:0] coh,
                               input logic [TAG_W-1:0] tag);
    wr_idx[w*IDX_W +: IDX_W]   = idx;
    wr_way_en[w*WAYS +: WAYS]  = way_en;
    wr_coh[w*2 +: 2]           = coh;
    wr_tag[w*TAG_W +: TAG_W]   = tag;
  endtask

  task automatic pushResp(input logic [NR-1:0] id, input logic [WAYS-1:0] way,
                          input logic hit, input logic [1:0] coh);
    resp_t e;
    e.id = id; e.way = way; e.hit = hit; e.coh = coh;
    exp_q.push_back(e);
  endtask

  // Presents one read and holds it until it is granted, within a bounded
  // wait. Called just after a posedge, and returns just after a posedge.
  task automatic issueRead(input int id, input logic [IDX_W-1:0] idx,
                           input logic [TAG_W-1:0] tag, input logic [NR-1:0] e_id,
                           input logic [WAYS-1:0] e_way, input logic e_hit,
                           input logic [1:0] e_coh);
    int   waited;
    logic fired;
    rd_idx[id*IDX_W +: IDX_W] = idx;
    rd_tag[id*TAG_W +: TAG_W] = tag;
    rd_valid[id] = 1'b1;
    pushResp(e_id, e_way, e_hit, e_coh);
    waited = 0;
    fired  = 1'b0;
    while (!fired && waited < 50) begin
      @(negedge clock);
      if (rd_ready[id]) fired = 1'b1;
      else waited++;
    end
    checkOutput("read_granted", fired, 1);
    @(posedge clock); #1;
    rd_valid[id] = 1'b0;
  endtask

  // Scoreboard monitor: each presented response must match the oldest queued
  // expectation.
  always @(negedge clock) begin
    resp_t e;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("resp_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("resp_id", resp_id, e.id);
        checkOutput("resp_hit_way", resp_hit_way, e.way);
        checkOutput("resp_hit", resp_hit, e.hit);
        checkOutput("resp_hit_coh", resp_hit_coh, e.coh);
      end
    end
  end

  initial begin
    int order [6];
    logic [NR-1:0] expg;
    order = '{0, 1, 2, 0, 1, 2};

    reset = 1'b1; array_up = 1'b0; array_block = 1'b0;
    rd_valid = '0; rd_idx = '0; rd_tag = '0;
    wr_valid = '0; wr_idx = '0; wr_way_en = '0; wr_coh = '0; wr_tag = '0;

    // Reset state. Reader 0 already requests, but the array is still down.
    rd_idx[0 +: IDX_W] = 6'd5;
    rd_valid[0] = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_rd_ready", rd_ready, 0);
    checkOutput("rst_wr_ready", wr_ready, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_id", resp_id, 0);
    checkOutput("rst_resp_hit_way", resp_hit_way, 0);
    checkOutput("rst_resp_hit", resp_hit, 0);
    checkOutput("rst_resp_hit_coh", resp_hit_coh, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Array init: 64 cycles with the array readies low.
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (c == 10 || c == 63) begin
        checkOutput("init_rd_ready", rd_ready, 0);
        checkOutput("init_resp_valid", resp_valid, 0);
      end
      @(posedge clock); #1;
    end
    array_up = 1'b1;
    pushResp(3'b001, 8'h00, 1'b0, 2'd0);
    @(negedge clock);
    checkOutput("first_rd_ready", rd_ready, 3'b001);
    checkOutput("first_read_idx", meta_read_idx, 5);
    @(posedge clock); #1;
    rd_valid[0] = 1'b0;
    @(negedge clock);
    checkOutput("first_resp_valid", resp_valid, 1);
    checkOutput("first_resp_id", resp_id, 3'b001);
    @(posedge clock); #1;

    // Round robin. Reader 2 goes first so that reader 0 is next in line.
    issueRead(2, 6'd1, 21'h0, 3'b100, 8'h00, 1'b0, 2'd0);
    rd_idx = {6'd12, 6'd11, 6'd10};
    rd_tag = '0;
    for (int n = 0; n < 6; n++) pushResp(NR'(1) << order[n], 8'h00, 1'b0, 2'd0);
    rd_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      if (n == 3) begin
        array_block = 1'b1;
        for (int b = 0; b < 3; b++) begin
          @(negedge clock);
          checkOutput("rr_blocked", rd_ready, 0);
          @(posedge clock); #1;
        end
        array_block = 1'b0;
      end
      expg = NR'(1) << order[n];
      @(negedge clock);
      checkOutput("rr_grant", rd_ready, expg);
      @(posedge clock); #1;
    end
    rd_valid = '0;
    repeat (2) @(posedge clock); #1;

    // Write priority: writer 0 goes before writer 1.
    applyStimulus(0, 6'd9, 8'h04, 2'd2, 21'h1ABCD);
    applyStimulus(1, 6'd20, 8'h01, 2'd1, 21'h00123);
    wr_valid = 2'b11;
    @(negedge clock);
    checkOutput("wr_ready_both", wr_ready, 2'b01);
    checkOutput("wr_idx_w0", meta_write_idx, 9);
    @(posedge clock); #1;
    wr_valid[0] = 1'b0;
    @(negedge clock);
    checkOutput("wr_ready_w1", wr_ready, 2'b10);
    checkOutput("wr_tag_w1", meta_write_tag, 21'h00123);
    @(posedge clock); #1;
    wr_valid = '0;

    // Tag compare: a hit, a near miss, and a hit on way 0.
    issueRead(0, 6'd9, 21'h1ABCD, 3'b001, 8'h04, 1'b1, 2'd2);
    issueRead(1, 6'd9, 21'h1ABCE, 3'b010, 8'h00, 1'b0, 2'd0);
    issueRead(2, 6'd20, 21'h00123, 3'b100, 8'h01, 1'b1, 2'd1);

    // Several hitting ways: the coherence state comes from the lowest way.
    applyStimulus(1, 6'd9, 8'h30, 2'd1, 21'h1ABCD);
    wr_valid = 2'b10;
    @(negedge clock);
    checkOutput("wr_ready_w1_alone", wr_ready, 2'b10);
    @(posedge clock); #1;
    wr_valid = '0;
    issueRead(0, 6'd9, 21'h1ABCD, 3'b001, 8'h34, 1'b1, 2'd2);

    // Write throttle while reader 1 is pending.
    applyStimulus(0, 6'd30, 8'h80, 2'd3, 21'h00005);
    wr_valid = 2'b01;
    rd_idx[1*IDX_W +: IDX_W] = 6'd30;
    rd_tag[1*TAG_W +: TAG_W] = 21'h00005;
    rd_valid[1] = 1'b1;
    pushResp(3'b010, 8'h80, 1'b1, 2'd3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checkOutput("thr_wr_ready", wr_ready[0], (c != 4));
      checkOutput("thr_rd_ready", rd_ready[1], (c == 4));
      @(posedge clock); #1;
      if (c == 4) rd_valid[1] = 1'b0;
    end
    wr_valid = '0;
    repeat (2) @(posedge clock); #1;

    // Reset lands on the same edge as a read fire, so the response is dropped.
    rd_idx[0 +: IDX_W] = 6'd40;
    rd_tag[0 +: TAG_W] = 21'h0;
    rd_valid[0] = 1'b1;
    @(negedge clock);
    checkOutput("rstmid_rd_ready", rd_ready, 3'b001);
    reset = 1'b1;
    @(posedge clock); #1;
    rd_valid = '0;
    @(negedge clock);
    checkOutput("rstmid_resp_valid", resp_valid, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // After reset, rr_ptr is NUM_READERS-1, so reader 0 beats reader 2.
    rd_idx[2*IDX_W +: IDX_W] = 6'd41;
    rd_tag[2*TAG_W +: TAG_W] = 21'h0;
    pushResp(3'b001, 8'h00, 1'b0, 2'd0);
    pushResp(3'b100, 8'h00, 1'b0, 2'd0);
    rd_valid = 3'b101;
    @(negedge clock);
    checkOutput("post_rst_grant0", rd_ready, 3'b001);
    @(posedge clock); #1;
    rd_valid[0] = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_grant2", rd_ready, 3'b100);
    @(posedge clock); #1;
    rd_valid = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
